// File: rtl/lvdc_timing_gen.sv
// ---------------------------------------------------------------------------
// lvdc_timing_gen
//   Parametrised LVDC master timing generator. From one master clock it
//   derives the sub-bit strobes (W/X/Y/Z at default), the bit-time count and
//   the phase count, plus end-of-phase and end-of-word pulses. A small
//   run/halt/step controller lets the machine free-run, halt cleanly at a
//   phase boundary, or execute exactly one phase while halted.
//
//   Three nested counters sit underneath: sc (sub-bit), bt (bit time) and
//   ph (phase). A counter holding an out-of-range value (upset or forced)
//   is cleared on the next edge and err pulses for one cycle.
//
// Ports
//   clk      in   master clock
//   rstn     in   asynchronous active-low reset
//   run      in   level; 1 = free-run, 0 = halt at the next phase boundary
//   step     in   pulse; while halted, run exactly one phase and halt again
//   syncn    in   active-low synchronous resync; clears sc/bt/ph only
//   sub      out  one-hot sub-bit strobe, sub[sc]; all 0 while halted
//   subn     out  complement of sub
//   bt/btn   out  bit time 0..NBITS-1 and its complement
//   ph/phn   out  phase 0..NPHASE-1 and its complement
//   phasep   out  high on the last clock of a phase
//   wordp    out  high on the last clock of a word
//   haltack  out  high while halted
//   err      out  one-cycle pulse after an illegal counter value was seen
// ---------------------------------------------------------------------------
module lvdc_timing_gen #(
   parameter int NSUB   = 4,
   parameter int NBITS  = 28,
   parameter int NPHASE = 3,
   parameter int BW     = $clog2(NBITS),
   parameter int PW     = (NPHASE > 2) ? $clog2(NPHASE) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              run,
   input  logic              step,
   input  logic              syncn,
   output logic [NSUB-1:0]   sub,
   output logic [NSUB-1:0]   subn,
   output logic [BW-1:0]     bt,
   output logic [BW-1:0]     btn,
   output logic [PW-1:0]     ph,
   output logic [PW-1:0]     phn,
   output logic              phasep,
   output logic              wordp,
   output logic              haltack,
   output logic              err
);

   localparam int SW  = (NSUB > 2) ? $clog2(NSUB) : 1;
   localparam int SW1 = SW + 1;
   localparam int BW1 = BW + 1;
   localparam int PW1 = PW + 1;

   // Terminal counts carried one bit wider than the counters so the
   // "greater than last legal value" test stays meaningful even when a
   // counter's range fills its register exactly.
   localparam logic [SW:0] SC_LAST = SW1'(NSUB - 1);
   localparam logic [BW:0] BT_LAST = BW1'(NBITS - 1);
   localparam logic [PW:0] PH_LAST = PW1'(NPHASE - 1);

   localparam logic [1:0] ST_HALTED  = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_HALTING = 2'd2;
   localparam logic [1:0] ST_STEP    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] sc_q, sc_d;
   logic [BW-1:0] bt_q, bt_nx;
   logic [PW-1:0] ph_q, ph_d;
   logic          err_q, err_d;

   // Next bit-time value as a net, so the bit-time register can be driven
   // to an arbitrary value from outside when exercising the range check.
   wire  [BW-1:0] bt_d;

   logic counting;
   logic sc_ill, bt_ill, ph_ill;
   logic sc_end, bt_end, ph_end;
   logic endphase;

   // ------------------------------------------------------------------
   // Decode of the registered state
   // ------------------------------------------------------------------
   always_comb begin
      counting = (state_q != ST_HALTED);
      sc_ill   = {1'b0, sc_q} > SC_LAST;
      bt_ill   = {1'b0, bt_q} > BT_LAST;
      ph_ill   = {1'b0, ph_q} > PH_LAST;
      sc_end   = {1'b0, sc_q} == SC_LAST;
      bt_end   = {1'b0, bt_q} == BT_LAST;
      ph_end   = {1'b0, ph_q} == PH_LAST;
      endphase = counting & sc_end & bt_end;
   end

   // ------------------------------------------------------------------
   // Counter next-state. Each counter is range-checked on its own: an
   // illegal one is cleared, the legal ones keep counting. Carries only
   // ripple out of a counter sitting at its legal terminal value, so an
   // illegal low-order counter never produces a spurious carry. Resync
   // wins over everything and does not flag an error.
   // ------------------------------------------------------------------
   always_comb begin
      sc_d  = sc_q;
      bt_nx = bt_q;
      ph_d  = ph_q;
      err_d = 1'b0;
      if (!syncn) begin
         sc_d  = '0;
         bt_nx = '0;
         ph_d  = '0;
      end else begin
         err_d = sc_ill | bt_ill | ph_ill;

         if (sc_ill)
            sc_d = '0;
         else if (counting)
            sc_d = sc_end ? '0 : sc_q + SW'(1);

         if (bt_ill)
            bt_nx = '0;
         else if (counting && sc_end)
            bt_nx = bt_end ? '0 : bt_q + BW'(1);

         if (ph_ill)
            ph_d = '0;
         else if (endphase)
            ph_d = ph_end ? '0 : ph_q + PW'(1);
      end
   end

   assign bt_d = bt_nx;

   // ------------------------------------------------------------------
   // Run/halt/step controller. Halting always finishes the current phase;
   // the counters wrap into the next phase on the same edge that enters
   // HALTED, so a halted machine rests at the start of a phase.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALTED: begin
            if (run)
               state_d = ST_RUN;
            else if (step)
               state_d = ST_STEP;
         end
         ST_RUN: begin
            if (!run)
               state_d = ST_HALTING;
         end
         ST_HALTING: begin
            if (run)
               state_d = ST_RUN;
            else if (endphase)
               state_d = ST_HALTED;
         end
         ST_STEP: begin
            // further step pulses are deliberately ignored here
            if (run)
               state_d = ST_RUN;
            else if (endphase)
               state_d = ST_HALTED;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_HALTED;
         sc_q    <= '0;
         bt_q    <= '0;
         ph_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         bt_q    <= bt_d;
         ph_q    <= ph_d;
         err_q   <= err_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: everything is decoded from registers only.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NSUB; i++) begin : g_sub
      assign sub[i] = counting && (sc_q == SW'(i));
   end

   assign subn    = ~sub;
   assign bt      = bt_q;
   assign btn     = ~bt_q;
   assign ph      = ph_q;
   assign phn     = ~ph_q;
   assign phasep  = endphase;
   assign wordp   = endphase & ph_end;
   assign haltack = (state_q == ST_HALTED);
   assign err     = err_q;

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lvdc_timing_gen
//   Directed bench for lvdc_timing_gen at default parameters. A reference
//   model tracks the machine as a linear position within the word plus a
//   run mode; a compare process checks every output against it on each
//   falling edge. Hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_lvdc_timing_gen;

   localparam int NSUB   = 4;
   localparam int NBITS  = 28;
   localparam int NPHASE = 3;
   localparam int TOT    = NSUB * NBITS * NPHASE;

   localparam int M_HALT = 0, M_RUN = 1, M_HALTING = 2, M_STEP = 3;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       run = 1'b0, step = 1'b0, syncn = 1'b1;
   logic [3:0] sub, subn;
   logic [4:0] bt, btn;
   logic [1:0] ph, phn;
   logic       phasep, wordp, haltack, err;

   int n_chk = 0, n_pass = 0;
   bit chk_on = 1'b0;
   bit inj_bt = 1'b0;

   int m_sc = 0, m_bt = 0, m_ph = 0, m_md = M_HALT;
   bit m_err = 1'b0;

   lvdc_timing_gen dut (
      .clk(clk), .rstn(rstn), .run(run), .step(step), .syncn(syncn),
      .sub(sub), .subn(subn), .bt(bt), .btn(btn), .ph(ph), .phn(phn),
      .phasep(phasep), .wordp(wordp), .haltack(haltack), .err(err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_step();
      bit cnt, endp, lsc, lbt, lph;
      int nm, p, nsc, nbt, nph;
      cnt  = (m_md != M_HALT);
      endp = cnt && m_sc == NSUB-1 && m_bt == NBITS-1;
      lsc  = m_sc < NSUB;
      lbt  = m_bt < NBITS;
      lph  = m_ph < NPHASE;
      case (m_md)
         M_HALT:    nm = run ? M_RUN : (step ? M_STEP : M_HALT);
         M_RUN:     nm = run ? M_RUN : M_HALTING;
         M_HALTING: nm = run ? M_RUN : (endp ? M_HALT : M_HALTING);
         default:   nm = run ? M_RUN : (endp ? M_HALT : M_STEP);
      endcase
      if (!syncn) begin
         m_sc = 0; m_bt = 0; m_ph = 0; m_err = 0;
      end else if (lsc && lbt && lph) begin
         if (cnt) begin
            p    = ((m_ph * NBITS + m_bt) * NSUB + m_sc + 1) % TOT;
            m_sc = p % NSUB;
            m_bt = (p / NSUB) % NBITS;
            m_ph = p / (NSUB * NBITS);
         end
         m_err = 0;
      end else begin
         nsc = !lsc ? 0 : (cnt ? (m_sc + 1) % NSUB : m_sc);
         nbt = !lbt ? 0 : ((cnt && m_sc == NSUB-1) ? (m_bt + 1) % NBITS : m_bt);
         nph = !lph ? 0 : (endp ? (m_ph + 1) % NPHASE : m_ph);
         m_sc = nsc; m_bt = nbt; m_ph = nph; m_err = 1;
      end
      if (inj_bt) m_bt = 30;
      m_md = nm;
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_sc = 0; m_bt = 0; m_ph = 0; m_md = M_HALT; m_err = 0;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         logic [3:0] esub;
         logic [4:0] ebt;
         logic [1:0] eph;
         logic       ecnt, ephp, ewp;
         ecnt = (m_md != M_HALT);
         esub = ecnt ? (4'b0001 << m_sc) : 4'b0000;
         ebt  = 5'(m_bt);
         eph  = 2'(m_ph);
         ephp = ecnt && m_sc == NSUB-1 && m_bt == NBITS-1;
         ewp  = ephp && m_ph == NPHASE-1;
         n_chk++;
         if (sub === esub && subn === ~esub && bt === ebt && btn === ~ebt &&
             ph === eph && phn === ~eph && phasep === ephp && wordp === ewp &&
             haltack === !ecnt && err === m_err)
            n_pass++;
         else
            $display("FAIL cycle @%0t: got sub=%b subn=%b bt=%0d btn=%0d ph=%0d phn=%0d p=%b w=%b h=%b e=%b, want sub=%b bt=%0d ph=%0d p=%b w=%b h=%b e=%b",
                     $time, sub, subn, bt, btn, ph, phn, phasep, wordp, haltack, err,
                     esub, ebt, eph, ephp, ewp, !ecnt, m_err);
      end
   end

   // ---------------- literal checks ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic wait_pos(input int wbt, input int wph, input logic [3:0] wsub, input string nm);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bt == 5'(wbt) && (wph < 0 || ph == 2'(wph)) && sub == wsub) return;
      end
      n_chk++;
      $display("FAIL %s: timeout waiting for bt=%0d ph=%0d", nm, wbt, wph);
   endtask

   initial begin
      int np, nw, first_p, wi, n, nc;

      #1 rstn = 1'b0;
      #1 chk_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst haltack", 32'(haltack), 32'd1);
      chk("rst sub",     32'(sub),     32'h0);
      chk("rst subn",    32'(subn),    32'hF);
      chk("rst bt/ph",   32'({bt, ph}), 32'h0);

      // free run over one full word
      #2 rstn = 1'b1;
      @(negedge clk); run = 1'b1;
      @(negedge clk);
      np = 0; nw = 0; first_p = -1; wi = -1;
      for (int i = 0; i < 336; i++) begin
         if (i < 4)        chk("run sub seq", 32'(sub), 32'(4'b0001 << i));
         if (i == 4)       chk("run bt after 4", 32'(bt), 32'd1);
         if (i % 112 == 0) chk("run ph seq", 32'(ph), 32'(i / 112));
         if (phasep) begin np++; if (first_p < 0) first_p = i; end
         if (wordp) begin nw++; wi = i; end
         @(negedge clk);
      end
      chk("word phasep count", 32'(np), 32'd3);
      chk("word first phasep", 32'(first_p), 32'd111);
      chk("word wordp count", 32'(nw), 32'd1);
      chk("word wordp index", 32'(wi), 32'd335);
      chk("word wrap", 32'({ph, bt, sub}), 32'({2'd0, 5'd0, 4'b0001}));

      // halt request mid-phase: drop at ph1 bt5 sc2
      wait_pos(5, 1, 4'b0100, "halt wait");
      run = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk); n++;
         if (haltack) break;
      end
      chk("halt clk count", 32'(n), 32'd90);
      chk("halt rest", 32'({haltack, sub, bt, ph}), 32'({1'b1, 4'b0000, 5'd0, 2'd2}));

      // single phase step with a stray step pulse in the middle
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      nc = 0; np = 0; nw = 0;
      for (int i = 0; i < 300; i++) begin
         if (haltack) break;
         if (sub != 4'b0000) nc++;
         if (phasep) np++;
         if (wordp) nw++;
         step = (nc == 50);
         @(negedge clk);
      end
      step = 1'b0;
      chk("step halted", 32'(haltack), 32'd1);
      chk("step count", 32'(nc), 32'd112);
      chk("step phasep", 32'(np), 32'd1);
      chk("step wordp", 32'(nw), 32'd1);
      chk("step rest", 32'({bt, ph}), 32'({5'd0, 2'd0}));

      // resync during run
      run = 1'b1;
      wait_pos(17, 2, 4'b0001, "sync wait");
      syncn = 1'b0;
      @(negedge clk); syncn = 1'b1;
      chk("sync pos", 32'({sub, bt, ph}), 32'({4'b0001, 5'd0, 2'd0}));
      chk("sync err/halt", 32'({err, haltack}), 32'd0);

      // illegal bit-time value
      wait_pos(10, -1, 4'b0001, "force wait");
      force dut.bt_d = 5'd30;
      inj_bt = 1'b1;
      @(negedge clk);
      release dut.bt_d;
      inj_bt = 1'b0;
      chk("forced bt", 32'({err, bt, sub}), 32'({1'b0, 5'd30, 4'b0010}));
      @(negedge clk);
      chk("range fix", 32'({err, bt, sub}), 32'({1'b1, 5'd0, 4'b0100}));
      @(negedge clk);
      chk("range err once", 32'({err, bt, sub}), 32'({1'b0, 5'd0, 4'b1000}));
      @(negedge clk);
      chk("range resume", 32'({bt, sub}), 32'({5'd1, 4'b0001}));

      // asynchronous reset mid-phase, release with run held
      wait_pos(9, -1, 4'b0001, "reset wait");
      #2 rstn = 1'b0;
      #1;
      chk("async rst", 32'({haltack, sub, subn, bt, ph, err}),
          32'({1'b1, 4'b0000, 4'b1111, 5'd0, 2'd0, 1'b0}));
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      chk("rst release", 32'({haltack, sub, bt}), 32'({1'b0, 4'b0001, 5'd0}));
      repeat (8) @(negedge clk);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lvdc_timing_gen.md
Name: lvdc_timing_gen

Overview:
Parametrised successor to the fixed LVDC timing module. Generates sub-bit clock strobes, bit-time count, phase count and word-boundary pulses from a single master clock. Sits between the clock logic and all downstream logic that currently decodes W/X/Y/Z, G1–G7 and PA/PB/PC. Adds run/halt/single-phase-step control, resync and counter-range self-check.

Parameters:
NSUB, 4, sub-bit clocks per bit time (W,X,Y,Z at default); min 2
NBITS, 28, bit times per phase; min 2
NPHASE, 3, phases per word cycle; min 2
BW, $clog2(NBITS), bit-time counter width
PW, $clog2(NPHASE) (min 1), phase counter width

Ports:
clk  in  1  master clock
rstn  in  1  asynchronous active-low reset
run  in  1  level; 1 = free-run, 0 = halt at next phase boundary
step  in  1  one-cycle pulse; while halted, run exactly one phase then halt
syncn  in  1  active-low synchronous resync; clears sc/bt/ph
sub  out  NSUB  one-hot sub-bit strobe, sub[sc]; all 0 when not counting
subn  out  NSUB  bitwise complement of sub
bt  out  BW  current bit time, 0..NBITS-1
btn  out  BW  complement of bt
ph  out  PW  current phase, 0..NPHASE-1
phn  out  PW  complement of ph
phasep  out  1  last clock of a phase
wordp  out  1  last clock of a word
haltack  out  1  1 while in HALTED
err  out  1  one-cycle pulse on illegal counter value

Behaviour:
- Reset (rstn=0, async): sc=0, bt=0, ph=0, state=HALTED. Outputs: sub=0, subn=all 1, bt=0, ph=0, phasep=0, wordp=0, haltack=1, err=0.
- Internal counters sc (0..NSUB-1), bt, ph. Counting = state in {RUN, HALTING, STEP}.
- Advance, each clk while counting: sc++. When sc==NSUB-1: sc->0 and bt++. When additionally bt==NBITS-1: bt->0 and ph++. When additionally ph==NPHASE-1: ph->0.
- Boundary terms are combinational from registered state:
  - endphase = counting & sc==NSUB-1 & bt==NBITS-1.
  - phasep = endphase.
  - wordp = endphase & ph==NPHASE-1.
- sub = counting ? onehot(sc) : 0. sub, bt and ph are decoded from registers only, with no input-to-output combinational path.
- State machine:
  - HALTED: run=1 -> RUN; else step=1 -> STEP; else stay. Counters frozen.
  - RUN: run=0 -> HALTING; else stay.
  - HALTING: run=1 -> RUN. Else, on endphase -> HALTED; counters wrap to the start of the next phase on that same edge.
  - STEP: run=1 -> RUN. Else, on endphase -> HALTED. step pulses while in STEP are ignored.
- Latency: run rises before edge n. State=RUN after edge n; sub[0] visible in that cycle; sc=1 after edge n+1.
- Halt always completes the current phase. A halted machine sits at sc=0, bt=0, ph=next phase.
- syncn=0 at an edge: sc=bt=ph=0, state unchanged. It overrides advance and range correction. err is not asserted.
- Range check, per counter: if sc>=NSUB, bt>=NBITS or ph>=NPHASE (SEU/forced), that counter loads 0 at the next edge and err pulses for one cycle. Legal counters advance normally.
- Simultaneous run=1 and step=1 in HALTED: run wins.
- Reset mid-operation: immediate return to reset values, regardless of state.

Test Plan:
- Defaults; reset, then run=1 held -> sub cycles 0001,0010,0100,1000; bt increments every 4 clks; phasep every 112 clks; wordp every 336 clks; ph sequence 0,1,2,0.
- run dropped at bt=5, ph=1 -> counting continues to bt=27, sc=3. Next edge: HALTED, haltack=1, sub=0, bt=0, ph=2. Total 90 clks after the drop edge.
- While halted at ph=2, single step pulse -> exactly 112 counting clks with one phasep. Then HALTED at ph=0, bt=0. A second step mid-run has no effect.
- syncn low for one clk during run at bt=17, ph=2 -> next cycle bt=0, ph=0, sub=0001, state RUN, err=0.
- Force bt=30 for one clk while running -> next cycle bt=0, err=1 for exactly one clk, sc continues unaffected.
- rstn asserted asynchronously mid-phase (bt=9) -> outputs immediately at reset values. Release with run=1 -> sub[0] in the first cycle after the next edge.
